demux_stream_param: RTL and testbench
=====================================

# demux_stream_param

Parametrised 1-to-NUM_OUT stream demultiplexer with per-output valid/ready handshake, one-entry output holding registers and packet-locked routing. It is the registered, flow-controlled successor to the team's combinational 1-to-4 demux. It sits between a single producer and NUM_OUT independent consumers. It routes whole packets, delimited by `in_last`, to the output chosen by `in_sel` on the packet's first beat.

## Interface
- `WIDTH`, default 8: data width per beat.
- `NUM_OUT`, default 4: number of output channels, at least 2.
- `SEL_W`, default 2: select width. Must satisfy 2^SEL_W ≥ NUM_OUT.

- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_data`  in  WIDTH  input beat.
- `in_sel`  in  SEL_W  destination channel; sampled only on the first beat of a packet.
- `in_last`  in  1  marks the final beat of a packet.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `out_data`  out  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_last`  out  NUM_OUT  per-channel last flag.
- `out_valid`  out  NUM_OUT  per-channel valid.
- `out_ready`  in  NUM_OUT  per-channel ready.
- `busy`  out  1  high while a packet is open (state PKT or DROP).
- `drop_cnt`  out  16  discarded-beat count. Present only with `DEMUX_DROP_CNT_EN`.

## Operation
- **FSM states.** IDLE, PKT and DROP. Registers `route` (SEL_W bits) and `state`.
- **Target channel.** `tgt` is `in_sel` when state is IDLE, and `route` otherwise.
- **Valid target.** `tgt < NUM_OUT`. An invalid target occurs only when NUM_OUT < 2^SEL_W.
- **Acceptance, valid target.** `in_ready = ~out_valid[tgt] | out_ready[tgt]`. This is a combinational pass-through of the target slot's drain.
- **Acceptance, invalid target, or state DROP.** `in_ready = 1`. The beat is discarded.
- **On acceptance in IDLE:**
  - `route <= in_sel`.
  - If `in_last` = 0: go to PKT (valid target) or DROP (invalid target).
  - If `in_last` = 1: single-beat packet; stay in IDLE.
- **On acceptance in PKT or DROP.** `in_sel` is ignored. When `in_last` = 1, return to IDLE.
- **Holding register k:**
  - Load `in_data`/`in_last` and set `out_valid[k]` on an accepted beat with target k.
  - Otherwise clear `out_valid[k]` when `out_valid[k] & out_ready[k]`.
  - Load and drain in the same cycle keeps `out_valid[k]` at 1 with the new data.
- **Non-target channels.** Unaffected; they drain independently.
- **Output data while invalid.** `out_data` and `out_last` keep their last loaded value while `out_valid` is 0.
- **Interleaving.** Packets are never interleaved. A new `in_sel` takes effect only after the previous `in_last` has been accepted.
- **`busy`.** Equals `state != IDLE`.

## Timing
- **Latency.** One cycle from input acceptance to `out_valid`.
- **Throughput.** One beat per cycle per packet while the target's `out_ready` is held high.
- **Back-to-back packets.** Packets to different channels run back to back with no bubble.
- **Reset (`rst_n` low at a rising edge):**
  - state = IDLE, `route` = 0.
  - All `out_valid` = 0, `out_data` = 0, `out_last` = 0.
  - `drop_cnt` = 0.
- **`in_ready` during reset.** Forced to 0 while `rst_n` is low.
- **Reset mid-packet.** Holding-register contents and the open packet are lost. The next accepted beat is treated as a first beat.
- **`in_valid` low mid-packet.** State and route are held indefinitely.
- **Output backpressure.** `out_ready[tgt]` low with the slot full gives `in_ready` = 0. Other slots still drain.

## Configuration
- **Macro:** `DEMUX_DROP_CNT_EN`.
- **Defined:**
  - `drop_cnt` port exists.
  - It increments by 1 on every accepted beat that is discarded: invalid-target first beats and all DROP-state beats.
  - It saturates at 16'hFFFF and is reset to 0.
- **Undefined:**
  - No `drop_cnt` port or counter logic.
  - Discard behaviour is otherwise identical.

## Test plan
- **Single-beat routing.** WIDTH=8, NUM_OUT=4, all `out_ready`=1. Send `in_data`=8'hA5, `in_sel`=2, `in_last`=1 → one cycle later `out_valid`=4'b0100 and channel 2 data = 8'hA5 for exactly one cycle; `busy` stays 0.
- **Packet lock.** Send a 3-beat packet 11/22/33 with `in_sel`=1 on the first beat and `in_sel`=3 on beats 2–3 → all three beats appear on channel 1 only; `out_last[1]` is set with 33; `busy` is high for 2 cycles.
- **Backpressure.** `out_ready[0]`=0; send 2 beats to channel 0 → first beat is held in `out_valid[0]`, `in_ready`=0 with beat 2 waiting. Raise `out_ready[0]` → beat 2 loads in the same cycle as the drain; no loss or duplication.
- **Invalid select (NUM_OUT=3, SEL_W=2).** Send a 4-beat packet with `in_sel`=3 → `in_ready`=1 on every beat; no `out_valid` asserted; `drop_cnt`=4 with the macro defined.
- **Mid-packet reset.** After beat 1 of a packet to channel 1, pull `rst_n` low for 1 cycle → all outputs read 0, `busy`=0. Next beat with `in_sel`=0 routes to channel 0.
- **Saturation (macro defined).** Force 65 540 discarded beats → `drop_cnt` holds at 16'hFFFF.

Source files
------------

// File: rtl/demux_stream_param.sv
// 1-to-NUM_OUT packet demux with one-entry holding slot per output and packet-locked routing.
// Optional discarded-beat counter enabled by DEMUX_DROP_CNT_EN.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

module demux_stream_param #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_last,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     busy
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   route_q, route_d;
  logic [SEL_W-1:0]   tgt;
  logic               route_ok;
  logic               accept;
  logic [NUM_OUT-1:0] hit;

  // route_ok low means the beat is discarded and never backpressures the source
  assign tgt      = (state_q == IDLE) ? in_sel : route_q;
  assign route_ok = (int'(tgt) < NUM_OUT) && (state_q != DROP);
  assign in_ready = rst_n & (~route_ok | (|(hit & (~out_valid | out_ready))));
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != IDLE);

  genvar k;
  generate
    for (k = 0; k < NUM_OUT; k++) begin : g_slot
      assign hit[k] = route_ok && (tgt == SEL_W'(k));
      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept & hit[k]),
        .data_i  (in_data),
        .last_i  (in_last),
        .ready_i (out_ready[k]),
        .valid_o (out_valid[k]),
        .data_o  (out_data[k*WIDTH +: WIDTH]),
        .last_o  (out_last[k])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      if (state_q == IDLE) begin
        route_d = in_sel;
        if (!in_last) state_d = route_ok ? PKT : DROP;
      end else if (in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                    drop_cnt_q <= '0;
    else if (accept && !route_ok && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_demux_stream_param.sv
// Scoreboard bench for demux_stream_param: NUM_OUT=3 so select 3 exercises the discard path.
module tb_demux_stream_param;
  localparam int W  = 8;
  localparam int NO = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    in_data;
  logic [SW-1:0]   in_sel;
  logic            in_last, in_valid, in_ready;
  logic [NO*W-1:0] out_data;
  logic [NO-1:0]   out_last, out_valid, out_ready;
  logic            busy;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0]     drop_cnt;
`endif

  int checks = 0;
  int passed = 0;
  int last_wait = 0;
  int exp_q [NO][$];

  always #5 clk = ~clk;

  demux_stream_param #(.WIDTH(W), .NUM_OUT(NO), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // exp_ch < 0 means the beat must be discarded
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l, input int exp_ch);
    int n;
    n = 0;
    in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    if (exp_ch < 0) chk("drop_in_ready", {31'd0, in_ready}, 32'd1);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (n >= 50) begin
      checks++;
      $display("FAIL accept_timeout: beat %0h never accepted", d);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (exp_ch >= 0) exp_q[exp_ch].push_back({23'd0, l, d});
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // monitor: every output handshake pops the scoreboard for that channel
  initial begin
    int e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NO; k++) begin
        if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat ch%0d: got %0h expected none", k, out_data[k*W +: W]);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("data_ch%0d", k), {24'd0, out_data[k*W +: W]}, {24'd0, e[7:0]});
            chk($sformatf("last_ch%0d", k), {31'd0, out_last[k]}, {31'd0, e[8]});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_sel = '0; in_last = 1'b0; in_data = '0;
    out_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {8'd0, out_data}, 32'd0);
    chk("rst_out_last",  {29'd0, out_last}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    chk("rst_drop_cnt",  {16'd0, drop_cnt}, 32'd0);
`endif
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single beat to channel 2, visible for exactly one cycle
    send(8'hA5, 2'd2, 1'b1, 2);
    idle();
    chk("single_valid", {29'd0, out_valid}, 32'b100);
    chk("single_busy",  {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("single_gone",  {29'd0, out_valid}, 32'd0);

    // packet lock: select changes on beats 2-3 are ignored
    send(8'h11, 2'd1, 1'b0, 1);
    chk("lock_busy1", {31'd0, busy}, 32'd1);
    send(8'h22, 2'd3, 1'b0, 1);
    chk("lock_busy2", {31'd0, busy}, 32'd1);
    send(8'h33, 2'd3, 1'b1, 1);
    idle();
    chk("lock_busy3", {31'd0, busy}, 32'd0);
    chk("lock_valid", {29'd0, out_valid}, 32'b010);
    repeat (2) @(posedge clk); #1;

    // backpressure on channel 0
    out_ready = 3'b110;
    send(8'hC1, 2'd0, 1'b0, 0);
    in_data = 8'hC2; in_sel = 2'd0; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_held",     {29'd0, out_valid}, 32'b001);
    chk("bp_data",     {24'd0, out_data[7:0]}, 32'hC1);
    @(posedge clk); #1;
    out_ready = 3'b111;
    send(8'hC2, 2'd0, 1'b1, 0);
    chk("bp_same_cycle", last_wait, 0);
    idle();
    chk("bp_reload", {29'd0, out_valid}, 32'b001);
    repeat (2) @(posedge clk); #1;

    // invalid select: whole packet discarded
    send(8'h40, 2'd3, 1'b0, -1);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    send(8'h41, 2'd0, 1'b0, -1);
    send(8'h42, 2'd1, 1'b0, -1);
    send(8'h43, 2'd3, 1'b1, -1);
    idle();
    chk("drop_busy_end", {31'd0, busy}, 32'd0);
    chk("drop_no_valid", {29'd0, out_valid}, 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt4", {16'd0, drop_cnt}, 32'd4);
`endif

    // back-to-back single beats to different channels, no bubble
    send(8'hB0, 2'd0, 1'b1, 0);
    send(8'hB2, 2'd2, 1'b1, 2);
    chk("b2b_nowait2", last_wait, 0);
    send(8'hB1, 2'd1, 1'b1, 1);
    chk("b2b_nowait3", last_wait, 0);
    idle();
    repeat (2) @(posedge clk); #1;

    // mid-packet reset
    send(8'hD1, 2'd1, 1'b0, 1);
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_valid", {29'd0, out_valid}, 32'd0);
    chk("mrst_data",  {8'd0, out_data}, 32'd0);
    chk("mrst_last",  {29'd0, out_last}, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    chk("mrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    send(8'hE0, 2'd0, 1'b1, 0);
    idle();
    chk("mrst_route0", {29'd0, out_valid}, 32'b001);
    repeat (2) @(posedge clk); #1;

`ifdef DEMUX_DROP_CNT_EN
    // counter saturation
    in_data = 8'h55; in_sel = 2'd3; in_last = 1'b0; in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("drop_sat", {16'd0, drop_cnt}, 32'h0000FFFF);
    in_last = 1'b1;
    @(posedge clk); #1;
    idle();
    chk("drop_sat_hold", {16'd0, drop_cnt}, 32'h0000FFFF);
    chk("drop_sat_idle", {31'd0, busy}, 32'd0);
`endif

    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < NO; k++) chk($sformatf("q_empty_ch%0d", k), exp_q[k].size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
